// File: rtl/keypad_scan.sv
// keypad_scan
// 4x4 matrix keypad scanner and debouncer for the calculator datapath.
// Drives the columns one at a time, samples the synchronized rows, builds a
// full-scan result and debounces it into a single clean key press.
//
// Parameters:
//   SCAN_DIV      clk cycles each column is driven (>= 4)
//   DB_SCANS      identical full scans needed to accept a press or release (>= 1)
//   REPEAT_SCANS  full scans between repeat strobes (autorepeat build only)
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   row_in     in   [3:0] keypad rows, active-low, asynchronous
//   col_out    out  [3:0] column drive, active-low, one-cold
//   KEY        out  [9:0] one-hot digit level, KEY[n] = digit n held
//   Add/Sub/Mul/Div out operator held levels
//   key_valid  out  one-cycle strobe on press acceptance
//   key_code   out  [3:0] position code of accepted key, row*4+col
//
// Optional feature: define KEYPAD_AUTOREPEAT_EN to re-pulse key_valid every
// REPEAT_SCANS full scans while a key stays held.

module keypad_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int DB_SCANS     = 4,
  parameter int REPEAT_SCANS = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [9:0] KEY,
  output logic       Add,
  output logic       Sub,
  output logic       Mul,
  output logic       Div,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W   = $clog2(DB_SCANS + 1);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
  localparam logic [DB_W-1:0]   DB_MAX    = DB_W'(DB_SCANS);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);

  typedef enum logic [1:0] {
    SCAN_NONE,
    SCAN_SINGLE,
    SCAN_MULTI
  } scan_kind_t;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  // ---------------------------------------------------------------------------
  // Row synchronizer (rows idle high because of the external pull-ups)
  // ---------------------------------------------------------------------------
  logic [3:0] row_s1, row_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1 <= 4'hF;
      row_s2 <= 4'hF;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Column scan and per-scan hit accumulation
  // ---------------------------------------------------------------------------
  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        col_idx;
  logic              slot_last;

  // acc_cnt saturates at 2: anything beyond one hit is simply "multi".
  logic [1:0]        acc_cnt;
  logic [3:0]        acc_code;

  logic [3:0]        col_hits;
  logic [2:0]        hit_n;
  logic [1:0]        hit_row;
  logic [2:0]        total_n;
  logic [1:0]        new_cnt;
  logic [3:0]        new_code;
  scan_kind_t        new_kind;

  logic              scan_end;
  scan_kind_t        scan_kind;
  logic [3:0]        scan_code;

  assign slot_last = (slot_cnt == SLOT_LAST);
  assign col_out   = ~(4'b0001 << col_idx);
  assign col_hits  = ~row_s2;

  // Count the rows pulled low for the column being sampled and merge them
  // with the hits already gathered earlier in this scan.
  always_comb begin
    hit_n   = 3'd0;
    hit_row = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (col_hits[r]) begin
        hit_n   = hit_n + 3'd1;
        hit_row = 2'(r);
      end
    end
    total_n  = {1'b0, acc_cnt} + hit_n;
    new_cnt  = (total_n >= 3'd2) ? 2'd2 : total_n[1:0];
    new_code = (hit_n == 3'd1 && acc_cnt == 2'd0) ? {hit_row, col_idx} : acc_code;
    case (new_cnt)
      2'd0:    new_kind = SCAN_NONE;
      2'd1:    new_kind = SCAN_SINGLE;
      default: new_kind = SCAN_MULTI;
    endcase
  end

  // Slot/column counters; the column 3 sample closes the scan and publishes
  // the result together with a one-cycle scan_end pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt  <= '0;
      col_idx   <= 2'd0;
      acc_cnt   <= 2'd0;
      acc_code  <= 4'd0;
      scan_end  <= 1'b0;
      scan_kind <= SCAN_NONE;
      scan_code <= 4'd0;
    end else begin
      scan_end <= 1'b0;
      if (slot_last) begin
        slot_cnt <= '0;
        col_idx  <= col_idx + 2'd1;
        if (col_idx == 2'd3) begin
          scan_end  <= 1'b1;
          scan_kind <= new_kind;
          scan_code <= new_code;
          acc_cnt   <= 2'd0;
          acc_code  <= 4'd0;
        end else begin
          acc_cnt  <= new_cnt;
          acc_code <= new_code;
        end
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce FSM
  // ---------------------------------------------------------------------------
  state_t          state, state_n;
  logic [3:0]      cand, cand_n;
  logic [DB_W-1:0] db_cnt, db_n, db_inc;
  logic            accept;
  logic            scan_single;
  logic            single_match;
  logic            rep_fire;
  logic            level_on;

  assign scan_single  = (scan_kind == SCAN_SINGLE);
  assign single_match = scan_single && (scan_code == cand);
  assign db_inc       = db_cnt + DB_ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cand   <= 4'd0;
      db_cnt <= '0;
    end else begin
      state  <= state_n;
      cand   <= cand_n;
      db_cnt <= db_n;
    end
  end

  // MULTI is treated exactly like NONE: only a single matching hit counts.
  always_comb begin
    state_n = state;
    cand_n  = cand;
    db_n    = db_cnt;
    accept  = 1'b0;
    if (scan_end) begin
      unique case (state)
        IDLE: begin
          if (scan_single) begin
            cand_n = scan_code;
            if (DB_SCANS == 1) begin
              state_n = HELD;
              db_n    = '0;
              accept  = 1'b1;
            end else begin
              state_n = PRESS_WAIT;
              db_n    = DB_ONE;
            end
          end
        end
        PRESS_WAIT: begin
          if (single_match) begin
            if (db_inc == DB_MAX) begin
              state_n = HELD;
              db_n    = '0;
              accept  = 1'b1;
            end else begin
              db_n = db_inc;
            end
          end else if (scan_single) begin
            cand_n = scan_code;
            db_n   = DB_ONE;
          end else begin
            state_n = IDLE;
            db_n    = '0;
          end
        end
        HELD: begin
          if (!single_match) begin
            if (DB_SCANS == 1) begin
              state_n = IDLE;
              db_n    = '0;
            end else begin
              state_n = RELEASE_WAIT;
              db_n    = DB_ONE;
            end
          end
        end
        RELEASE_WAIT: begin
          if (single_match) begin
            state_n = HELD;
            db_n    = '0;
          end else if (db_inc == DB_MAX) begin
            state_n = IDLE;
            db_n    = '0;
          end else begin
            db_n = db_inc;
          end
        end
        default: begin
          state_n = IDLE;
          db_n    = '0;
        end
      endcase
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  // ---------------------------------------------------------------------------
  // Autorepeat: counts scans spent in HELD; a glitch through RELEASE_WAIT
  // back into HELD keeps the count, only a fresh acceptance clears it.
  // ---------------------------------------------------------------------------
  localparam int REP_W = $clog2(REPEAT_SCANS + 1);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_SCANS);

  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_inc;

  assign rep_inc  = rep_cnt + REP_W'(1);
  assign rep_fire = scan_end && (state == HELD) && single_match && (rep_inc == REP_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (accept) begin
      rep_cnt <= '0;
    end else if (scan_end && state == HELD && single_match) begin
      rep_cnt <= rep_fire ? '0 : rep_inc;
    end
  end
`else
  // No repeat strobes in this build; REPEAT_SCANS has no effect.
  assign rep_fire = (REPEAT_SCANS < 0);
`endif

  // ---------------------------------------------------------------------------
  // Registered strobe, code and level enable
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      level_on  <= 1'b0;
    end else begin
      key_valid <= accept | rep_fire;
      if (accept) begin
        key_code <= cand_n;
        level_on <= 1'b1;
      end else if (state_n == IDLE) begin
        level_on <= 1'b0;
      end
    end
  end

  // key_code always holds the currently held key while level_on is set,
  // so the level outputs decode straight from it. C (12) and = (14) drive
  // no level output.
  always_comb begin
    KEY = 10'd0;
    Add = 1'b0;
    Sub = 1'b0;
    Mul = 1'b0;
    Div = 1'b0;
    if (level_on) begin
      case (key_code)
        4'd0:    KEY[1] = 1'b1;
        4'd1:    KEY[2] = 1'b1;
        4'd2:    KEY[3] = 1'b1;
        4'd3:    Add    = 1'b1;
        4'd4:    KEY[4] = 1'b1;
        4'd5:    KEY[5] = 1'b1;
        4'd6:    KEY[6] = 1'b1;
        4'd7:    Sub    = 1'b1;
        4'd8:    KEY[7] = 1'b1;
        4'd9:    KEY[8] = 1'b1;
        4'd10:   KEY[9] = 1'b1;
        4'd11:   Mul    = 1'b1;
        4'd13:   KEY[0] = 1'b1;
        4'd15:   Div    = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan
// Directed bench for keypad_scan with SCAN_DIV=4, DB_SCANS=2, REPEAT_SCANS=3.
// A behavioural keypad pulls a row low whenever a pressed key's column is
// driven. One full scan is 16 cycles; key changes are applied on scan
// boundaries so each scan sees a stable key set.

module tb_keypad_scan;

  localparam int SCAN_DIV     = 4;
  localparam int DB_SCANS     = 2;
  localparam int REPEAT_SCANS = 3;
  localparam int SCAN_CYC     = 4 * SCAN_DIV;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int EXP_REP = 3;
`else
  localparam int EXP_REP = 1;
`endif

  localparam logic [15:0] K_1   = 16'h0001;
  localparam logic [15:0] K_12  = 16'h0003;
  localparam logic [15:0] K_ADD = 16'h0008;
  localparam logic [15:0] K_5   = 16'h0020;
  localparam logic [15:0] K_7   = 16'h0100;
  localparam logic [15:0] K_DIV = 16'h8000;

  logic       clk;
  logic       rst_n;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [9:0] KEY;
  logic       Add, Sub, Mul, Div;
  logic       key_valid;
  logic [3:0] key_code;

  logic [15:0] pressed;

  int errors = 0;
  int checks = 0;
  int vcount = 0;
  int onehot_bad = 0;
  bit add_seen = 0;
  bit div_watch = 0;
  bit div_drop = 0;
  int vstart;

  keypad_scan #(
    .SCAN_DIV(SCAN_DIV),
    .DB_SCANS(DB_SCANS),
    .REPEAT_SCANS(REPEAT_SCANS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .row_in(row_in),
    .col_out(col_out),
    .KEY(KEY),
    .Add(Add),
    .Sub(Sub),
    .Mul(Mul),
    .Div(Div),
    .key_valid(key_valid),
    .key_code(key_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix model: a pressed key shorts its row to its driven column.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
  end

  // Observers sampled on the falling edge.
  always @(negedge clk) begin
    if (rst_n && key_valid) vcount++;
    if ($countones({KEY, Add, Sub, Mul, Div}) > 1) onehot_bad++;
    if (Add) add_seen = 1'b1;
    if (div_watch && !Div) div_drop = 1'b1;
  end

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hold a key set for a number of full scans (called on a scan boundary).
  task automatic applyStimulus(input logic [15:0] keys, input int scans);
    pressed = keys;
    repeat (scans * SCAN_CYC) @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_col;

    $display("[TB] start");
    pressed = 16'h0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    checkOutput("reset_col",   16'(col_out),   16'hE);
    checkOutput("reset_key",   16'(KEY),       16'h0);
    checkOutput("reset_ops",   16'({Add, Sub, Mul, Div}), 16'h0);
    checkOutput("reset_valid", 16'(key_valid), 16'h0);
    checkOutput("reset_code",  16'(key_code),  16'h0);

    // Column walk after release: one column per SCAN_DIV cycles
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_col = ~(4'b0001 << i);
      checkOutput($sformatf("col_step%0d", i), 16'(col_out), 16'(exp_col));
      repeat (SCAN_DIV) @(negedge clk);
    end
    checkOutput("col_wrap", 16'(col_out), 16'hE);

    // Press 5: accepted one cycle after the second matching scan_end
    vstart = vcount;
    applyStimulus(K_5, 2);
    checkOutput("press5_not_early", 16'(KEY), 16'h0);
    @(negedge clk);
    checkOutput("press5_key",   16'(KEY),       16'h020);
    checkOutput("press5_valid", 16'(key_valid), 16'h1);
    checkOutput("press5_code",  16'(key_code),  16'h5);
    repeat (SCAN_CYC - 1) @(negedge clk);
    applyStimulus(K_5, 1);
    checkOutput("press5_one_strobe", 16'(vcount - vstart), 16'h1);
    checkOutput("press5_held", 16'(KEY), 16'h020);
    applyStimulus(16'h0, 2);
    checkOutput("release5_not_early", 16'(KEY), 16'h020);
    @(negedge clk);
    checkOutput("release5_key",  16'(KEY),      16'h0);
    checkOutput("release5_code", 16'(key_code), 16'h5);
    repeat (SCAN_CYC - 1) @(negedge clk);

    // Bounce: '+' only on alternate scans is never accepted
    vstart   = vcount;
    add_seen = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus((i % 2 == 0) ? K_ADD : 16'h0, 1);
    applyStimulus(16'h0, 2);
    checkOutput("bounce_add",   16'(add_seen),        16'h0);
    checkOutput("bounce_valid", 16'(vcount - vstart), 16'h0);

    // Multi-key: '1'+'2' ignored, then '1' alone accepted
    vstart = vcount;
    applyStimulus(K_12, 3);
    checkOutput("multi_key",   16'(KEY),             16'h0);
    checkOutput("multi_valid", 16'(vcount - vstart), 16'h0);
    applyStimulus(K_1, 2);
    @(negedge clk);
    checkOutput("multi_one_key",   16'(KEY),       16'h002);
    checkOutput("multi_one_code",  16'(key_code),  16'h0);
    checkOutput("multi_one_valid", 16'(key_valid), 16'h1);
    repeat (SCAN_CYC - 1) @(negedge clk);
    applyStimulus(16'h0, 3);
    checkOutput("multi_release", 16'(KEY), 16'h0);

    // Release glitch on '/': one empty scan does not release it
    vstart = vcount;
    applyStimulus(K_DIV, 2);
    @(negedge clk);
    checkOutput("glitch_div_on", 16'(Div), 16'h1);
    div_watch = 1'b1;
    repeat (SCAN_CYC - 1) @(negedge clk);
    applyStimulus(16'h0, 1);
    applyStimulus(K_DIV, 3);
    div_watch = 1'b0;
    checkOutput("glitch_div_held", 16'(Div),             16'h1);
    checkOutput("glitch_no_drop",  16'(div_drop),        16'h0);
    checkOutput("glitch_strobes",  16'(vcount - vstart), 16'h1);
    checkOutput("glitch_code",     16'(key_code),        16'hF);
    applyStimulus(16'h0, 3);
    checkOutput("glitch_release", 16'(Div), 16'h0);

    // Reset mid-hold on '7'
    applyStimulus(K_7, 2);
    @(negedge clk);
    checkOutput("hold7_key", 16'(KEY), 16'h080);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_key",  16'(KEY),      16'h0);
    checkOutput("midreset_col",  16'(col_out),  16'hE);
    checkOutput("midreset_code", 16'(key_code), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(K_7, 2);
    @(negedge clk);
    checkOutput("reaccept7_key",   16'(KEY),       16'h080);
    checkOutput("reaccept7_valid", 16'(key_valid), 16'h1);
    repeat (SCAN_CYC - 1) @(negedge clk);
    applyStimulus(16'h0, 3);
    checkOutput("release7_key", 16'(KEY), 16'h0);

    // Long hold of '7': single strobe, or repeats when autorepeat is built in
    vstart = vcount;
    applyStimulus(K_7, 10);
    repeat (2) @(negedge clk);
    checkOutput("repeat_strobes", 16'(vcount - vstart), 16'(EXP_REP));
    checkOutput("repeat_key",     16'(KEY),             16'h080);
    applyStimulus(16'h0, 3);
    checkOutput("repeat_release", 16'(KEY), 16'h0);

    checkOutput("onehot_levels", 16'(onehot_bad), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
